pio_in_edge_irq: RTL and testbench



---
 rtl/pio_pkg.sv | 14 +
 rtl/pio_in_edge_irq_if.sv | 23 ++
 rtl/pio_in_sync.sv | 47 ++++
 rtl/pio_in_edge_irq.sv | 74 +++++++
 tb/tb_pio_in_edge_irq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared register map and capture-mode constants for the input PIO.
package pio_pkg;
    localparam int unsigned PIO_ADDR_W = 2;

    typedef logic [PIO_ADDR_W-1:0] pio_addr_t;

    localparam pio_addr_t PIO_ADDR_DATA    = 2'd0;
    localparam pio_addr_t PIO_ADDR_IRQMASK = 2'd2;
    localparam pio_addr_t PIO_ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;
endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO, including its interrupt line.
interface pio_in_edge_irq_if #(
    parameter int unsigned WIDTH = 8
) ();
    import pio_pkg::*;

    pio_addr_t          address;
    logic               chipselect;
    logic               write_n;
    logic [WIDTH-1:0]   writedata;
    logic [WIDTH-1:0]   readdata;
    logic               irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_in_sync.sv
// Multi-stage input synchroniser with a delayed copy for per-bit edge events.
module pio_in_sync
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] evt_c
);
    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync   = chain[SYNC_STAGES-1];
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

    always_comb begin
        evt_c = rise_c;
        if (EDGE_TYPE == EDGE_FALLING) begin
            evt_c = fall_c;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            evt_c = rise_c | fall_c;
        end
    end
endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised level read-back, W1C edge capture, masked IRQ.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    pio_in_edge_irq_if.slave bus
);
    localparam int unsigned ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] evt_c;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] rd_c;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed_c;
    logic             wr_c;

    pio_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .sync    (sync),
        .evt_c   (evt_c)
    );

    assign wr_c    = bus.chipselect & ~bus.write_n;
    assign armed_c = (arm_cnt == ARM_MAX);
    assign clr_c   = (wr_c && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata : '0;

    // Read mux sees pre-write register values, so a same-cycle write is not reflected.
    always_comb begin
        rd_c = '0;
        case (bus.address)
            PIO_ADDR_DATA:    rd_c = sync;
            PIO_ADDR_IRQMASK: rd_c = mask;
            PIO_ADDR_EDGECAP: rd_c = edgecap;
            default:          rd_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt      <= '0;
            mask         <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            if (!armed_c) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (wr_c && bus.address == PIO_ADDR_IRQMASK) begin
                mask <= bus.writedata;
            end
            // Event ORed after the clear so a coincident event wins.
            edgecap      <= (edgecap & ~clr_c) | (armed_c ? evt_c : '0);
            bus.readdata <= rd_c;
            bus.irq      <= |(edgecap & mask);
        end
    end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed scoreboard bench for pio_in_edge_irq: 8-bit rising and 16-bit any-edge instances.
module tb_pio_in_edge_irq;
    import pio_pkg::*;

    typedef struct {
        string       tag;
        bit          sel16;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  in8;
    logic [15:0] in16;
    int          checks;
    int          failures;
    exp_t        sb[$];

    pio_in_edge_irq_if #(.WIDTH(8))  bus8  ();
    pio_in_edge_irq_if #(.WIDTH(16)) bus16 ();

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .in_port (in8),
        .bus     (bus8.slave)
    );

    pio_in_edge_irq #(.WIDTH(16), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)) dut16 (
        .clk     (clk),
        .reset   (reset),
        .in_port (in16),
        .bus     (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive on negedge, push expectation, pop and compare 1 after posedge.
    task automatic cyc(input bit sel16, input logic [1:0] addr, input bit wr,
                       input logic [31:0] wd, input bit chk,
                       input logic [31:0] exp_rd, input logic exp_irq, input string tag);
        exp_t        e;
        logic [31:0] obs_rd;
        logic        obs_irq;
        @(negedge clk);
        bus8.chipselect  = 1'b0;
        bus8.write_n     = 1'b1;
        bus16.chipselect = 1'b0;
        bus16.write_n    = 1'b1;
        if (sel16) begin
            bus16.address    = addr;
            bus16.chipselect = wr;
            bus16.write_n    = ~wr;
            bus16.writedata  = wd[15:0];
        end else begin
            bus8.address    = addr;
            bus8.chipselect = wr;
            bus8.write_n    = ~wr;
            bus8.writedata  = wd[7:0];
        end
        if (chk) sb.push_back('{tag, sel16, exp_rd, exp_irq});
        @(posedge clk);
        #1;
        if (chk) begin
            e       = sb.pop_front();
            obs_rd  = e.sel16 ? 32'(bus16.readdata) : 32'(bus8.readdata);
            obs_irq = e.sel16 ? bus16.irq : bus8.irq;
            checks++;
            assert (obs_rd === e.rd) else begin
                failures++;
                $error("FAIL %s readdata observed=%h expected=%h", e.tag, obs_rd, e.rd);
            end
            checks++;
            assert (obs_irq === e.irq) else begin
                failures++;
                $error("FAIL %s irq observed=%b expected=%b", e.tag, obs_irq, e.irq);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, PIO_ADDR_DATA, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "idle");
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        in8             = 8'hFF;
        in16            = 16'h0000;
        bus8.address    = PIO_ADDR_DATA;
        bus8.chipselect = 1'b0;
        bus8.write_n    = 1'b1;
        bus8.writedata  = '0;
        bus16.address   = PIO_ADDR_DATA;
        bus16.chipselect = 1'b0;
        bus16.write_n   = 1'b1;
        bus16.writedata = '0;

        // Reset with inputs held high.
        cyc(1'b0, PIO_ADDR_DATA, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "reset8");
        cyc(1'b1, PIO_ADDR_DATA, 1'b0, 32'h0, 1'b1, 32'h0000, 1'b0, "reset16");
        reset = 1'b0;
        idle(10);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "no_spurious_cap");
        cyc(1'b0, PIO_ADDR_DATA,    1'b0, 32'h0, 1'b1, 32'hFF, 1'b0, "data_ff");
        cyc(1'b0, 2'd1,             1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "reserved_zero");

        // Falling edges are ignored in rising mode; mask read returns pre-write value.
        in8 = 8'h00;
        idle(4);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, "fall_ignored");
        cyc(1'b0, PIO_ADDR_IRQMASK, 1'b1, 32'h01, 1'b1, 32'h00, 1'b0, "mask_wr_old");
        cyc(1'b0, PIO_ADDR_IRQMASK, 1'b0, 32'h0,  1'b1, 32'h01, 1'b0, "mask_rd_new");

        // Rising bit0: capture at edge t+2, visible in readdata and irq after t+3.
        in8 = 8'h01;
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "rise_t0");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "rise_t1");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "rise_t2");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h01, 1'b1, "rise_t3");
        cyc(1'b0, PIO_ADDR_DATA,    1'b0, 32'h0, 1'b1, 32'h01, 1'b1, "data_01");
        in8 = 8'h00;
        idle(4);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h01, 1'b1, "fall_no_new");

        // Write-1-to-clear drops irq on the following edge.
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b1, 32'h01, 1'b1, 32'h01, 1'b1, "clr_wr");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, "clr_done");

        // Writing zero leaves captures alone; unmasked bit gives no irq.
        in8 = 8'h02;
        idle(4);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b1, 32'h00, 1'b1, 32'h02, 1'b0, "wr_zero");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0,  1'b1, 32'h02, 1'b0, "wr_zero_keep");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b1, 32'h02, 1'b1, 32'h02, 1'b0, "clr_bit1");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, "clr_bit1_done");
        in8 = 8'h00;
        idle(4);

        // Clear of bit3 coincides with its capture edge: event wins.
        in8 = 8'h08;
        idle(2);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b1, 32'h08, 1'b1, 32'h00, 1'b0, "race_wr");
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, "race_keep");
        in8 = 8'h00;
        idle(4);

        // Any-edge 16-bit instance.
        in16 = 16'hA5A5;
        idle(4);
        cyc(1'b1, PIO_ADDR_EDGECAP, 1'b0, 32'h0,    1'b1, 32'hA5A5, 1'b0, "any_first");
        cyc(1'b1, PIO_ADDR_EDGECAP, 1'b1, 32'hFFFF, 1'b1, 32'hA5A5, 1'b0, "any_clr");
        in16 = 16'h5A5A;
        idle(4);
        cyc(1'b1, PIO_ADDR_EDGECAP, 1'b0, 32'h0,    1'b1, 32'hFFFF, 1'b0, "any_toggle");
        cyc(1'b1, PIO_ADDR_IRQMASK, 1'b1, 32'h8000, 1'b1, 32'h0000, 1'b0, "any_mask_wr");
        cyc(1'b1, PIO_ADDR_IRQMASK, 1'b0, 32'h0,    1'b1, 32'h8000, 1'b1, "any_mask_irq");
        cyc(1'b1, PIO_ADDR_DATA,    1'b0, 32'h0,    1'b1, 32'h5A5A, 1'b1, "any_data");

        // Mid-operation reset with captures pending and irq high.
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b1, 32'hFF, 1'b0, 32'h0, 1'b0, "pre_clr");
        in8 = 8'h0F;
        idle(4);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h0F, 1'b1, "pre_reset");
        reset = 1'b1;
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "rearm_window");
        end
        cyc(1'b0, PIO_ADDR_IRQMASK, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, "mask_after_reset");
        cyc(1'b1, PIO_ADDR_IRQMASK, 1'b0, 32'h0, 1'b1, 32'h0000, 1'b0, "mask16_after_reset");
        in8 = 8'h1F;
        idle(3);
        cyc(1'b0, PIO_ADDR_EDGECAP, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, "rearmed_cap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
